dmem_mmio: RTL and testbench

Data-side memory stage directly downstream of the single-cycle core: consumes memwrite, aluout (as addr) and writedata, and returns readdata combinationally in the same cycle. It holds a word-addressed data RAM and a small memory-mapped peripheral page. The page contains a free-running timer with a compare interrupt and a byte TX FIFO with a valid/ready output. It replaces the plain data memory in the top level; the core is unchanged.

---
 rtl/mmio_pkg.sv | 13 +
 rtl/sync_fifo.sv | 40 ++++
 rtl/dmem_mmio.sv | 93 +++++++++
 tb/tb_dmem_mmio.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: register map, STATUS bit positions and reset values for dmem_mmio
package mmio_pkg;
    localparam logic [7:0] OFF_COUNT   = 8'h00;
    localparam logic [7:0] OFF_COMPARE = 8'h04;
    localparam logic [7:0] OFF_STATUS  = 8'h08;
    localparam logic [7:0] OFF_TXDATA  = 8'h0C;
    localparam logic [7:0] OFF_CTRL    = 8'h10;
    localparam int ST_MATCH = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;
    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, extra pointer bit separates full from empty
// Ports: clk, reset (async active-low), push/din write side, pop/dout read side
// (dout is 0 when empty), full, empty status.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_push;
    logic         w_pop;
    assign empty  = r_wr == r_rd;
    assign full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = empty ? '0 : r_mem[r_rd[AW-1:0]];
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= din;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end
endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: data RAM plus memory-mapped timer and TX FIFO page for the core
// Ports: clk, reset (async active-low); memwrite/addr/writedata from the core,
// readdata combinational load data; tx_data/tx_valid/tx_ready byte stream out;
// irq = timer match flag gated by irq_en.
module dmem_mmio
    import mmio_pkg::*;
#(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);
    localparam int RAW = $clog2(RAM_WORDS);
    logic [31:0] r_ram [RAM_WORDS];
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_match;
    logic        r_ovf;
    logic        r_irq_en;
    logic        w_ram_hit;
    logic        w_mmio_hit;
    logic [7:0]  w_off;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_tx;
    logic        w_wr_ctrl;
    logic        w_full;
    logic        w_empty;
    logic [31:0] w_status;
    logic [31:0] w_mmio_rd;
    assign w_ram_hit    = addr < 32'(RAM_WORDS * 4);
    assign w_mmio_hit   = addr[31:8] == MMIO_BASE[31:8];
    assign w_off        = {addr[7:2], 2'b00};
    assign w_wr_compare = memwrite & w_mmio_hit & (w_off == OFF_COMPARE);
    assign w_wr_status  = memwrite & w_mmio_hit & (w_off == OFF_STATUS);
    assign w_wr_tx      = memwrite & w_mmio_hit & (w_off == OFF_TXDATA);
    assign w_wr_ctrl    = memwrite & w_mmio_hit & (w_off == OFF_CTRL);
    always_comb begin
        w_status           = '0;
        w_status[ST_MATCH] = r_match;
        w_status[ST_FULL]  = w_full;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_OVF]   = r_ovf;
        w_mmio_rd = (w_off == OFF_COUNT)   ? r_count   :
                    (w_off == OFF_COMPARE) ? r_compare :
                    (w_off == OFF_STATUS)  ? w_status  :
                    (w_off == OFF_CTRL)    ? {31'd0, r_irq_en} : '0;
        readdata  = w_ram_hit  ? r_ram[addr[RAW+1:2]] :
                    w_mmio_hit ? w_mmio_rd : '0;
    end
    always_ff @(posedge clk) begin
        if (memwrite & w_ram_hit) r_ram[addr[RAW+1:2]] <= writedata;
    end
    // A match on the same edge as a W1C keeps the flag set; a push into a
    // full FIFO (judged before the edge) is dropped and latches overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count   <= '0;
            r_compare <= COMPARE_RST;
            r_match   <= 1'b0;
            r_ovf     <= 1'b0;
            r_irq_en  <= 1'b0;
        end else begin
            r_count <= r_count + 32'd1;
            if (w_wr_compare) r_compare <= writedata;
            r_match <= (r_count == r_compare) | (r_match & ~(w_wr_status & writedata[ST_MATCH]));
            r_ovf   <= (w_wr_tx & w_full) | (r_ovf & ~(w_wr_status & writedata[ST_OVF]));
            if (w_wr_ctrl) r_irq_en <= writedata[0];
        end
    end
    sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_wr_tx & ~w_full),
        .pop   (tx_ready),
        .din   (writedata[7:0]),
        .dout  (tx_data),
        .full  (w_full),
        .empty (w_empty)
    );
    assign tx_valid = ~w_empty;
    assign irq      = r_match & r_irq_en;
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed self-checking bench for dmem_mmio
module tb_dmem_mmio;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        irq;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] c;

    localparam logic [31:0] A_COUNT   = 32'hFFFF_0000;
    localparam logic [31:0] A_COMPARE = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS  = 32'hFFFF_0008;
    localparam logic [31:0] A_TXDATA  = 32'hFFFF_000C;
    localparam logic [31:0] A_CTRL    = 32'hFFFF_0010;

    dmem_mmio dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        addr      = a;
        writedata = d;
        @(negedge clk);
        memwrite  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, readdata, exp);
    endtask

    initial begin
        @(posedge clk);
        #2;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rd("rst_compare", A_COMPARE, 32'hFFFF_FFFF);
        rd("rst_status", A_STATUS, 32'h4);
        // timer: count=0 now
        wr(A_COMPARE, 32'd10);
        wr(A_CTRL, 32'd1);
        repeat (8) @(negedge clk);
        rd("count_10", A_COUNT, 32'd10);
        rd("status_pre_match", A_STATUS, 32'h4);
        check("irq_pre_match", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rd("status_match", A_STATUS, 32'h5);
        check("irq_match", {31'd0, irq}, 32'd1);
        wr(A_COMPARE, 32'd15);
        repeat (3) @(negedge clk);
        rd("count_15", A_COUNT, 32'd15);
        wr(A_STATUS, 32'h1);
        rd("status_set_wins", A_STATUS, 32'h5);
        wr(A_STATUS, 32'h1);
        rd("status_w1c", A_STATUS, 32'h4);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        wr(A_COUNT, 32'd0);
        rd("count_ro", A_COUNT, 32'd18);
        rd("ctrl_rd", A_CTRL, 32'd1);
        // RAM and decode
        wr(32'h18, 32'd0);
        wr(32'h0, 32'd0);
        wr(32'h14, 32'hDEAD_BEEF);
        rd("ram_14", 32'h14, 32'hDEAD_BEEF);
        rd("ram_17", 32'h17, 32'hDEAD_BEEF);
        rd("ram_18", 32'h18, 32'h0);
        rd("unmapped_rd", 32'h1234_5678, 32'h0);
        addr = 32'h14; writedata = 32'h1; memwrite = 1'b1;
        #1;
        check("ram_rd_old", readdata, 32'hDEAD_BEEF);
        @(negedge clk);
        memwrite = 1'b0;
        rd("ram_new", 32'h14, 32'h1);
        wr(32'h100, 32'h7);
        rd("ram_edge_alias", 32'h0, 32'h0);
        rd("ram_edge_rd", 32'h100, 32'h0);
        rd("mmio_undef", 32'hFFFF_0020, 32'h0);
        rd("txdata_rd", A_TXDATA, 32'h0);
        // FIFO fill and overflow
        for (int i = 0; i < 5; i++) wr(A_TXDATA, 32'h41 + i);
        rd("status_full_ovf", A_STATUS, 32'hA);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_valid", {31'd0, tx_valid}, 32'd1);
            check("drain_data", {24'd0, tx_data}, 32'h41 + i);
            @(negedge clk);
        end
        #1;
        check("drained_valid", {31'd0, tx_valid}, 32'd0);
        check("drained_data", {24'd0, tx_data}, 32'd0);
        @(negedge clk);
        rd("status_empty_ovf", A_STATUS, 32'hC);
        wr(A_STATUS, 32'h8);
        rd("status_ovf_clr", A_STATUS, 32'h4);
        // push while full with simultaneous pop: push dropped
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr(A_TXDATA, i);
        tx_ready = 1'b1;
        wr(A_TXDATA, 32'h55);
        tx_ready = 1'b0;
        rd("status_pushpop_full", A_STATUS, 32'h8);
        tx_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            #1;
            check("pp_data", {24'd0, tx_data}, i);
            @(negedge clk);
        end
        #1;
        check("pp_empty", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
        wr(A_STATUS, 32'h8);
        // simultaneous push/pop mid-occupancy keeps order
        wr(A_TXDATA, 32'h61);
        wr(A_TXDATA, 32'h62);
        tx_ready = 1'b1;
        wr(A_TXDATA, 32'h63);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("order_data", {24'd0, tx_data}, 32'h62 + i);
            @(negedge clk);
        end
        #1;
        check("order_empty", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
        rd("status_order", A_STATUS, 32'h4);
        // mid-operation reset
        wr(A_TXDATA, 32'h71);
        wr(A_TXDATA, 32'h72);
        addr = A_COUNT;
        #1;
        c = readdata;
        wr(A_COMPARE, c + 32'd3);
        repeat (3) @(negedge clk);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        check("pre_rst_valid", {31'd0, tx_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, tx_valid}, 32'd0);
        check("async_rst_data", {24'd0, tx_data}, 32'd0);
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        #1;
        reset = 1'b1;
        @(negedge clk);
        rd("post_rst_status", A_STATUS, 32'h4);
        rd("post_rst_compare", A_COMPARE, 32'hFFFF_FFFF);
        rd("post_rst_ctrl", A_CTRL, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
